// File: rtl/arb_pkg.sv
// Shared types and constants for the 8x16 round-robin bus arbiter.
// Widths are fixed by the existing Mux8Way16 data path.
package arb_pkg;

  localparam int N_PORTS = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef logic [DATA_W-1:0] word_t;

  function automatic logic [N_PORTS-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    return {{(N_PORTS-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/Mux8Way16.sv
// 8-way 16-bit selector shared by all requesters.
// Purely combinational; sel picks one of a..h.
module Mux8Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  always_comb begin
    unique case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      default: out = h;
    endcase
  end

endmodule

// File: rtl/bus_arbiter8x16_rr_pick.sv
// Combinational round-robin picker: first set req bit
// scanning upward from ptr, wrapping modulo 8.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter8x16.sv
// Round-robin arbiter sequencing the Mux8Way16 select so
// 8 producers share one 16-bit valid/ready consumer.
module bus_arbiter8x16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PORTS-1:0]       req,
  input  logic [N_PORTS-1:0]       last,
  input  logic [7:0][DATA_W-1:0]   in_data,
  input  logic                     out_ready,
  output logic [N_PORTS-1:0]       gnt,
  output logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     busy
);

  arb_state_t       state_q, state_d;
  logic [N_PORTS-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             found;
  logic [SEL_W-1:0] win;
  logic             xfer;
  logic [3:0]       cnt_inc;
  logic             rel;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  Mux8Way16 u_mux (
    .a   (in_data[0]),
    .b   (in_data[1]),
    .c   (in_data[2]),
    .d   (in_data[3]),
    .e   (in_data[4]),
    .f   (in_data[5]),
    .g   (in_data[6]),
    .h   (in_data[7]),
    .sel (sel_q),
    .out (out_data)
  );

  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign busy      = (state_q == GRANT);
  assign gnt       = gnt_q;
  assign sel       = sel_q;

  assign xfer    = out_valid && out_ready;
  assign cnt_inc = cnt_q + 4'd1;

  // A withdrawn request abandons the grant without a transfer.
  always_comb begin
    rel = 1'b0;
    unique case (1'b1)
      !req[sel_q]:              rel = 1'b1;
      xfer && last[sel_q]:      rel = 1'b1;
      xfer && (cnt_inc == 4'(MAX_BURST)):
                                rel = 1'b1;
      default:                  rel = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = onehot(win);
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
          cnt_d   = 4'd0;
        end else if (xfer) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter8x16.sv
// Bench for bus_arbiter8x16: vector table, round-robin
// sweep and burst-limit sequence, checked via a queue.
module tb_bus_arbiter8x16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       req = '0;
  logic [7:0]       last = '0;
  logic [7:0][15:0] in_data;
  logic             out_ready = 1'b0;
  logic [7:0]       gnt;
  logic [2:0]       sel;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] dat [8];

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] last;
    logic       rdy;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       vld;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        vld;
    logic        busy;
    logic [15:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  bus_arbiter8x16 #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .in_data   (in_data),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int idx,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] q,
                     input logic [7:0] l, input logic rd,
                     input logic [7:0] g, input logic [2:0] s,
                     input logic v, input logic b);
    vec_t x;
    x.rst = r; x.req = q; x.last = l; x.rdy = rd;
    x.gnt = g; x.sel = s; x.vld = v; x.busy = b;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic r, input logic [7:0] q,
                       input logic [7:0] l, input logic rd);
    @(posedge clk);
    #1;
    rst_n = r; req = q; last = l; out_ready = rd;
  endtask

  task automatic expect_out(input logic [7:0] g,
                            input logic [2:0] s,
                            input logic v, input logic b);
    exp_t e;
    e.gnt = g; e.sel = s; e.vld = v; e.busy = b;
    e.data = dat[s];
    sb.push_back(e);
  endtask

  task automatic check_out(input int idx);
    exp_t e;
    #3;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty @%0d got 0 want 1", idx);
    end else begin
      e = sb.pop_front();
      cmp("gnt", idx, 16'(gnt), 16'(e.gnt));
      cmp("sel", idx, 16'(sel), 16'(e.sel));
      cmp("valid", idx, 16'(out_valid), 16'(e.vld));
      cmp("busy", idx, 16'(busy), 16'(e.busy));
      cmp("data", idx, out_data, e.data);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q,
                      input logic [7:0] l, input logic rd,
                      input logic [7:0] g, input logic [2:0] s,
                      input logic v, input logic b,
                      input int idx);
    drive(r, q, l, rd);
    expect_out(g, s, v, b);
    check_out(idx);
  endtask

  initial begin
    int xfers;
    bit seen;
    bit done;
    dat[0] = 16'h1234; dat[1] = 16'h1111;
    dat[2] = 16'h2222; dat[3] = 16'h4567;
    dat[4] = 16'h4444; dat[5] = 16'h5555;
    dat[6] = 16'h6666; dat[7] = 16'h7777;
    for (int i = 0; i < 8; i++) in_data[i] = dat[i];

    // reset
    add(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    // single beat with last, then ptr=1 check
    add(1, 8'h01, 8'h01, 1, 8'h00, 0, 0, 0);
    add(1, 8'h01, 8'h01, 1, 8'h01, 0, 1, 1);
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 8'h03, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 8'h03, 8'h00, 0, 8'h02, 1, 1, 1);
    add(1, 8'h00, 8'h00, 0, 8'h02, 1, 0, 1);
    add(1, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0);
    // stall on requester 5, then four beats
    add(1, 8'h20, 8'hFF, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(1, 8'h20, 8'h00, 0, 8'h20, 5, 1, 1);
    for (int i = 0; i < 4; i++)
      add(1, 8'h20, 8'hDF, 1, 8'h20, 5, 1, 1);
    add(1, 8'h00, 8'h00, 0, 8'h00, 5, 0, 0);
    // requester 7 withdraws, ptr wraps to 0
    add(1, 8'h80, 8'h00, 0, 8'h00, 5, 0, 0);
    add(1, 8'h80, 8'h00, 0, 8'h80, 7, 1, 1);
    add(1, 8'h01, 8'h00, 0, 8'h80, 7, 0, 1);
    add(1, 8'h01, 8'h00, 0, 8'h00, 7, 0, 0);
    add(1, 8'h01, 8'h00, 0, 8'h01, 0, 1, 1);
    add(1, 8'h00, 8'h00, 0, 8'h01, 0, 0, 1);
    // async reset mid-grant
    add(1, 8'h04, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 8'h04, 8'h00, 0, 8'h04, 2, 1, 1);
    add(0, 8'h04, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].rdy,
           tbl[i].gnt, tbl[i].sel, tbl[i].vld, tbl[i].busy, i);

    // full round-robin sweep, one idle cycle per grant
    for (int g = 0; g < 9; g++) begin
      step(1, 8'hFF, 8'hFF, 1, 8'h00,
           (g == 0) ? 3'd0 : 3'((g - 1) % 8), 0, 0, 100 + 2 * g);
      step(1, 8'hFF, 8'hFF, 1, 8'(1) << (g % 8),
           3'(g % 8), 1, 1, 101 + 2 * g);
    end

    // burst limit on requester 3
    xfers = 0;
    seen = 0;
    done = 0;
    drive(1, 8'h00, 8'h00, 0);
    for (int c = 0; c < 30 && !done; c++) begin
      drive(1, 8'h08, 8'h00, 1);
      #3;
      if (gnt == 8'h08) begin
        seen = 1;
        if (out_valid) xfers++;
        cmp("burst_data", c, out_data, dat[3]);
      end else if (seen) begin
        done = 1;
      end
    end
    cmp("burst_done", 200, 16'(done), 16'd1);
    cmp("burst_len", 201, 16'(xfers), 16'd4);

    drive(1, 8'h00, 8'h00, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter8x16.md
Name: bus_arbiter8x16

Overview:
Round-robin arbiter that shares one 16-bit output bus among 8 requesters by sequencing the existing 8-way 16-bit mux's select input.
- Grants one requester at a time and holds the grant for a burst.
- Enforces a downstream valid/ready handshake.
- Sits between 8 producer blocks and a single 16-bit consumer, e.g. a register or memory write port.

Parameters:
- MAX_BURST, default 4: maximum beats per grant before forced release; legal range 1..15.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 8: per-requester request/valid; bit i high means requester i has a beat on in_data[i].
- last, input, 8: per-requester end-of-burst marker; sampled only on a transfer from the granted requester.
- in_data, input, 8x16 packed, [7:0][15:0]: requester data; in_data[i] belongs to requester i.
- out_ready, input, 1: consumer accepts a beat this cycle.
- gnt, output, 8: one-hot grant, registered.
- sel, output, 3: index of the current/last grantee, registered; drives the mux select.
- out_data, output, 16: in_data[sel], combinational through the mux.
- out_valid, output, 1: beat offered to the consumer.
- busy, output, 1: high while in GRANT.

Behaviour:
- Reset (async assert, sync deassert is upstream's responsibility):
  - state=IDLE, gnt=8'h00, sel=3'd0, ptr=3'd0, beat_cnt=0.
  - out_valid=0; busy=0; out_data shows in_data[0].
- Transfer: occurs in a cycle when out_valid && out_ready.
- out_valid = (state==GRANT) && req[sel]. It is never high in IDLE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit of req, scanning ptr, ptr+1, ... wrapping mod 8.
  - At the next edge: sel<=winner, gnt<=1<<winner, beat_cnt<=0, state<=GRANT.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - On each transfer, beat_cnt increments.
  - Release at the edge when any of these holds:
    (a) transfer with last[sel]=1;
    (b) transfer that makes beat_cnt reach MAX_BURST;
    (c) req[sel]==0. The requester withdrew, no transfer happened, and the grant is abandoned.
  - Release actions: state<=IDLE, gnt<=0, ptr<=sel+1 (mod 8, 7 wraps to 0), beat_cnt<=0. sel keeps its value.
  - When none of (a)-(c) holds, hold the grant. out_ready low stalls without penalty and does not count against MAX_BURST.
- Turnaround: after every release, gnt stays 0 for exactly one IDLE cycle before the next grant.
  - Best-case throughput for back-to-back single-beat requesters is 1 beat per 2 cycles.
- Fairness: a requester continuously requesting is granted within 7 other grants.
- last is ignored from non-granted requesters and in IDLE.
- req[i] for i!=sel changing during GRANT has no effect until the next IDLE arbitration.
- Invariants: gnt is zero or one-hot, and gnt==(1<<sel) whenever state==GRANT.
- Reset mid-burst: immediately returns to the reset values. The in-flight beat is lost; no partial state is retained.
- Simultaneous release and new requests: the new requests are evaluated in the following IDLE cycle with the updated ptr.

Decomposition:
- Package arb_pkg:
  - N_PORTS=8, SEL_W=3, DATA_W=16.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - typedef logic [DATA_W-1:0] word_t.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
- The data path instantiates the existing Mux8Way16 with in_data[0..7] on a..h and sel.

Test Plan:
1. Reset with rst_n=0 mid-GRANT (req=8'h04) -> the same cycle gnt=0, busy=0, out_valid=0, sel=0; after release with req=0, the block stays IDLE.
2. req=8'h01, in_data[0]=16'h1234, last[0]=1, out_ready=1 -> one cycle later gnt=8'h01, sel=0, out_valid=1, out_data=16'h1234; the next cycle gnt=0 and ptr=1.
3. req=8'hFF held, last=8'hFF, out_ready=1 -> grant order 0,1,2,...,7,0, one IDLE cycle between grants; sel sequence 0..7 and wraps.
4. req=8'h08 held, last=0, MAX_BURST=4, in_data[3]=16'h4567 -> exactly 4 transfers, then release; out_data=16'h4567 throughout.
5. req=8'h20 granted, out_ready=0 for 5 cycles, then 1 -> gnt stays 8'h20, out_valid=1, no release; beat_cnt starts counting only after out_ready rises.
6. req=8'h80 granted, then req[7] dropped with req=8'h01 pending -> release with no transfer; ptr wraps to 0; the next grant is 8'h01 with sel=0 and out_data=in_data[0].
